alu_share_arb: RTL
==================

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width (fixed; other values unsupported).
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports, i in {0,1}: req{i}_valid  in  1  requester i has an op pending.
REQ-005 SHALL have ports: req{i}_ready  out  1  request accepted this cycle.
REQ-006 SHALL have ports: req{i}_op  in  4  ALU operand code; req{i}_type  in  3  instruction type.
REQ-007 SHALL have ports: req{i}_rs1, req{i}_rs2, req{i}_imm, req{i}_pc  in  32 each  operands.
REQ-008 SHALL have ports: rsp{i}_valid  out  1; rsp{i}_ready  in  1; rsp{i}_result  out  32.
REQ-009 SHALL have ports: alu_operand  out  4; alu_instr_type  out  3; alu_rs1, alu_rs2, alu_imm, alu_pc  out  32 each; alu_result  in  32 (ALU combinational result).
REQ-010 SHALL have ports: busy  out  1  FSM not IDLE; grant_id  out  1  owner of current op; ops_done  out  16  completed-op count.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-012 In IDLE with any req{i}_valid high, SHALL assert req{w}_ready combinationally for exactly one winner w, latch winner's op/type/rs1/rs2/imm/pc, set grant_id=w, go to EXEC.
REQ-013 Both valid in IDLE: SHALL grant the requester not granted last (round-robin); loser's ready stays 0.
REQ-014 In EXEC, alu_* outputs SHALL equal the latched operands; alu_result SHALL be registered into the result register at the EXEC cycle edge; next state RESP.
REQ-015 In IDLE and RESP, alu_* outputs SHALL be driven to zero.
REQ-016 In RESP, rsp{grant_id}_valid SHALL be 1 and rsp{grant_id}_result stable; other rsp valid SHALL be 0.
REQ-017 RESP with rsp{grant_id}_ready=1 SHALL return to IDLE next cycle, record grant_id as last-granted, increment ops_done; ready=0 SHALL hold RESP indefinitely.
REQ-018 Latency: handshake at edge N -> rsp_valid high from cycle N+2; minimum 3 cycles per op; no new request accepted outside IDLE.
REQ-019 ops_done SHALL wrap from 16'hFFFF to 0.
REQ-020 req{i}_ready SHALL be 0 in EXEC and RESP regardless of req{i}_valid.
REQ-021 rsp{i}_result for the non-owner SHALL read 0.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, last-granted=1 (requester 0 wins first), grant_id=0, ops_done=0, result register=0, all req_ready/rsp_valid=0, busy=0.
REQ-023 rst mid-EXEC or mid-RESP SHALL abandon the op without response or ops_done increment.

Configuration
REQ-024 Macro ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win simultaneous requests; when undefined, REQ-013 round-robin applies.

Verification
REQ-025 After reset, req0 ADD (op=0010,type=000) rs1=5, rs2=7 -> req0_ready at cycle 0, rsp0_valid cycle 2, rsp0_result=12, ops_done=1.
REQ-026 Both valid every cycle, rsp_ready tied 1 -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> grants 0,0,0,0.
REQ-027 req1 AUIPC (op=1000) pc=0x100, imm=0x20, rsp1_ready held 0 for 5 cycles -> rsp1_valid held, result=0x120 stable, req0_ready stays 0.
REQ-028 rst asserted during EXEC of req0 op -> next cycle busy=0, no rsp0_valid, ops_done unchanged.
REQ-029 Preload ops_done to 0xFFFF via 65535 ops (or force) then one op -> ops_done=0.

Source files
------------

// File: rtl/alu_share_arb.sv
// Two-requester arbiter that time-shares one external combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win ties; round-robin otherwise.
module alu_share_arb #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [2:0]      req0_type,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  input  logic [XLEN-1:0] req0_imm,
  input  logic [XLEN-1:0] req0_pc,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [2:0]      req1_type,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  input  logic [XLEN-1:0] req1_imm,
  input  logic [XLEN-1:0] req1_pc,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic [3:0]      alu_operand,
  output logic [2:0]      alu_instr_type,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [XLEN-1:0] alu_imm,
  output logic [XLEN-1:0] alu_pc,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy,
  output logic            grant_id,
  output logic [15:0]     ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0]      op;
    logic [2:0]      typ;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } req_t;

  state_t          r_state, w_state_nxt;
  req_t            r_req;
  req_t            w_req [2];
  logic [1:0]      w_valid;
  logic            w_win;
  logic            w_grant;
  logic            w_rsp_rdy;
  logic            r_last;
  logic            r_gid;
  logic [XLEN-1:0] r_result;
  logic [15:0]     r_ops_done;

  assign w_req[0] = '{op: req0_op, typ: req0_type, rs1: req0_rs1,
                      rs2: req0_rs2, imm: req0_imm, pc: req0_pc};
  assign w_req[1] = '{op: req1_op, typ: req1_type, rs1: req1_rs1,
                      rs2: req1_rs2, imm: req1_imm, pc: req1_pc};
  assign w_valid  = {req1_valid, req0_valid};

  // Tie-break: the requester not granted last, unless fixed priority is built in.
  always_comb begin
    w_win = 1'b0;
    if (w_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_win = 1'b0;
`else
      w_win = ~r_last;
`endif
    end else if (w_valid[1]) begin
      w_win = 1'b1;
    end
  end

  assign w_grant    = (r_state == IDLE) && (|w_valid);
  assign req0_ready = w_grant && !w_win;
  assign req1_ready = w_grant &&  w_win;
  assign w_rsp_rdy  = r_gid ? rsp1_ready : rsp0_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_rsp_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_last     <= 1'b1;
      r_gid      <= 1'b0;
      r_result   <= '0;
      r_ops_done <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_req <= w_req[w_win];
        r_gid <= w_win;
      end
      if (r_state == EXEC) r_result <= alu_result;
      if ((r_state == RESP) && w_rsp_rdy) begin
        r_last     <= r_gid;
        r_ops_done <= r_ops_done + 16'd1;
      end
    end
  end

  // ALU sees operands only while executing; zero otherwise.
  always_comb begin
    alu_operand    = '0;
    alu_instr_type = '0;
    alu_rs1        = '0;
    alu_rs2        = '0;
    alu_imm        = '0;
    alu_pc         = '0;
    if (r_state == EXEC) begin
      alu_operand    = r_req.op;
      alu_instr_type = r_req.typ;
      alu_rs1        = r_req.rs1;
      alu_rs2        = r_req.rs2;
      alu_imm        = r_req.imm;
      alu_pc         = r_req.pc;
    end
  end

  assign rsp0_valid  = (r_state == RESP) && !r_gid;
  assign rsp1_valid  = (r_state == RESP) &&  r_gid;
  assign rsp0_result = r_gid ? '0 : r_result;
  assign rsp1_result = r_gid ? r_result : '0;

  assign busy     = (r_state != IDLE);
  assign grant_id = r_gid;
  assign ops_done = r_ops_done;

endmodule
